// File: rtl/dram_pkg.sv
// Shared definitions for the DRAM controller host-side sequencer: FSM states,
// configuration step count and bit positions inside the configuration bytes
// that the dram_controller decodes.
package dram_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_CFG_LO,
    ST_CFG_HI,
    ST_IDLE,
    ST_ACC_LO,
    ST_ACC_WAIT,
    ST_GAP
  } state_e;

  localparam int CFG_STEPS = 11;

  // Step 2 byte layout
  localparam int CFG2_COL_LSB        = 0;
  localparam int CFG2_COL_MSB        = 3;
  localparam int CFG2_RDY_POL_BIT    = 4;
  localparam int CFG2_PAGE_MODE_BIT  = 5;
  localparam int CFG2_DATA_SETUP_BIT = 6;
  localparam int CFG2_DELAY_RDY_BIT  = 7;

  // Step 10 (final) byte layout
  localparam int CFG10_UNLOCK_BIT    = 0;
  localparam int CFG10_A17_CONF_BIT  = 1;
  localparam int CFG10_PAUSE_REF_BIT = 7;

endpackage

// File: rtl/dram_cfg_sequencer.sv
// Host-side front end for dram_controller: replays the 11-step configuration
// write sequence after reset, then turns level host requests into CSn/RWn
// bus cycles and tracks the controller's RDY handshake.
//
//   state       | meaning
//   ------------+----------------------------------------------------
//   PWRUP       | wait POWERUP_CYC cycles after reset
//   CFG_LO      | config write, CSn and CONFn low, byte on addr[7:0]
//   CFG_HI      | CSn high gap between config writes
//   IDLE        | config done, waiting for a host request
//   ACC_LO      | first cycle of an access, controller drops RDY
//   ACC_WAIT    | wait for busy-then-ready, or timeout
//   GAP         | CSn high gap after an access
//
// All bus outputs are registered so the controller sees glitch-free pins.
module dram_cfg_sequencer
  import dram_pkg::*;
#(
  parameter logic [15:0] REFRESH_IVL  = 16'd200,
  parameter logic [3:0]  COL_BITS     = 4'd7,
  parameter logic        RDY_POL      = 1'b0,
  parameter logic        PAGE_MODE    = 1'b1,
  parameter logic        DATA_SETUP   = 1'b0,
  parameter logic        DELAY_RDY    = 1'b0,
  parameter logic [55:0] DELAYS       = 56'h0,
  parameter logic        PAUSE_ON_REF = 1'b0,
  parameter int          POWERUP_CYC  = 16,
  parameter int          CS_LOW_CYC   = 2,
  parameter int          CS_HIGH_CYC  = 2,
  parameter int          WAIT_TIMEOUT = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        host_req_i,
  input  logic        host_we_i,
  input  logic [17:0] host_addr_i,
  output logic        host_ack_o,
  output logic        host_err_o,
  output logic        cfg_done_o,
  output logic        cs_n_o,
  output logic        rw_n_o,
  output logic        conf_n_o,
  output logic [17:0] addr_o,
  input  logic        rdy_i
);

  localparam logic [15:0] PWRUP_TC  = 16'(POWERUP_CYC - 1);
  localparam logic [15:0] LO_TC     = 16'(CS_LOW_CYC - 1);
  localparam logic [15:0] HI_TC     = 16'(CS_HIGH_CYC - 1);
  localparam logic [15:0] WAIT_TC   = 16'(WAIT_TIMEOUT - 1);
  localparam logic [3:0]  LAST_STEP = 4'(CFG_STEPS - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]  step_q, step_d, cfg_sel;
  logic        seen_busy_q, seen_busy_d;
  logic        cs_n_q, cs_n_d, rw_n_q, rw_n_d, conf_n_q, conf_n_d;
  logic [17:0] addr_q, addr_d;
  logic        ack_q, ack_d, err_q, err_d, done_q, done_d;
  logic [7:0]  cfg_byte;
  logic        ready;

  assign ready   = rdy_i ^ RDY_POL;
  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  // Byte needed is the one for the step about to be entered.
  assign cfg_sel = (state_q == ST_PWRUP) ? 4'd0 : step_q + 4'd1;

  // Configuration byte for the selected step, built from parameters.
  always_comb begin
    cfg_byte = 8'h00;
    case (cfg_sel)
      4'd0: cfg_byte = REFRESH_IVL[7:0];
      4'd1: cfg_byte = REFRESH_IVL[15:8];
      4'd2: begin
        cfg_byte[CFG2_COL_MSB:CFG2_COL_LSB] = COL_BITS;
        cfg_byte[CFG2_RDY_POL_BIT]          = RDY_POL;
        cfg_byte[CFG2_PAGE_MODE_BIT]        = PAGE_MODE;
        cfg_byte[CFG2_DATA_SETUP_BIT]       = DATA_SETUP;
        cfg_byte[CFG2_DELAY_RDY_BIT]        = DELAY_RDY;
      end
      4'd3: cfg_byte = DELAYS[7:0];
      4'd4: cfg_byte = DELAYS[15:8];
      4'd5: cfg_byte = DELAYS[23:16];
      4'd6: cfg_byte = DELAYS[31:24];
      4'd7: cfg_byte = DELAYS[39:32];
      4'd8: cfg_byte = DELAYS[47:40];
      4'd9: cfg_byte = DELAYS[55:48];
      4'd10: begin
        // Unlock bit cleared locks out further config; A17-on-CONFn kept
        // clear so CONFn stays high during normal accesses.
        cfg_byte[CFG10_UNLOCK_BIT]    = 1'b0;
        cfg_byte[CFG10_A17_CONF_BIT]  = 1'b0;
        cfg_byte[CFG10_PAUSE_REF_BIT] = PAUSE_ON_REF;
      end
      default: cfg_byte = 8'h00;
    endcase
  end

  // Next-state and next-output logic for the sequencer FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_inc;
    step_d      = step_q;
    seen_busy_d = seen_busy_q;
    cs_n_d      = cs_n_q;
    rw_n_d      = rw_n_q;
    conf_n_d    = conf_n_q;
    addr_d      = addr_q;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    done_d      = done_q;
    unique case (state_q)
      ST_PWRUP: begin
        if (cnt_q == PWRUP_TC) begin
          state_d  = ST_CFG_LO;
          cnt_d    = '0;
          step_d   = '0;
          cs_n_d   = 1'b0;
          conf_n_d = 1'b0;
          addr_d   = {10'b0, cfg_byte};
        end
      end
      ST_CFG_LO: begin
        if (cnt_q == LO_TC) begin
          state_d = ST_CFG_HI;
          cnt_d   = '0;
          cs_n_d  = 1'b1;
        end
      end
      ST_CFG_HI: begin
        if (cnt_q == HI_TC) begin
          cnt_d = '0;
          if (step_q == LAST_STEP) begin
            state_d  = ST_IDLE;
            conf_n_d = 1'b1;
            done_d   = 1'b1;
            addr_d   = '0;
          end else begin
            state_d = ST_CFG_LO;
            step_d  = step_q + 4'd1;
            cs_n_d  = 1'b0;
            addr_d  = {10'b0, cfg_byte};
          end
        end
      end
      ST_IDLE: begin
        cnt_d = '0;
        if (host_req_i) begin
          state_d     = ST_ACC_LO;
          seen_busy_d = 1'b0;
          cs_n_d      = 1'b0;
          rw_n_d      = ~host_we_i;
          addr_d      = host_addr_i;
        end
      end
      ST_ACC_LO: begin
        state_d = ST_ACC_WAIT;
        cnt_d   = '0;
      end
      ST_ACC_WAIT: begin
        if (!ready) seen_busy_d = 1'b1;
        // A ready level only counts once the controller has shown busy,
        // otherwise a stale RDY or a refresh would end the access early.
        if (seen_busy_q && ready) begin
          state_d = ST_GAP;
          cnt_d   = '0;
          cs_n_d  = 1'b1;
          rw_n_d  = 1'b1;
          ack_d   = 1'b1;
        end else if (cnt_q == WAIT_TC) begin
          state_d = ST_GAP;
          cnt_d   = '0;
          cs_n_d  = 1'b1;
          rw_n_d  = 1'b1;
          err_d   = 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == HI_TC) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_PWRUP;
    endcase
  end

  // State and registered outputs, synchronous reset from any state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_PWRUP;
      cnt_q       <= '0;
      step_q      <= '0;
      seen_busy_q <= 1'b0;
      cs_n_q      <= 1'b1;
      rw_n_q      <= 1'b1;
      conf_n_q    <= 1'b1;
      addr_q      <= '0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      step_q      <= step_d;
      seen_busy_q <= seen_busy_d;
      cs_n_q      <= cs_n_d;
      rw_n_q      <= rw_n_d;
      conf_n_q    <= conf_n_d;
      addr_q      <= addr_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      done_q      <= done_d;
    end
  end

  assign cs_n_o     = cs_n_q;
  assign rw_n_o     = rw_n_q;
  assign conf_n_o   = conf_n_q;
  assign addr_o     = addr_q;
  assign host_ack_o = ack_q;
  assign host_err_o = err_q;
  assign cfg_done_o = done_q;

endmodule

// File: tb/tb_dram_cfg_sequencer.sv
// Bench for dram_cfg_sequencer. Two instances run in lockstep on the same
// host stimulus: dut0 with default parameters and normal RDY, dut1 with
// RDY_POL=1 fed the inverted RDY plus non-default config bytes.
module tb_dram_cfg_sequencer;

  localparam int POWERUP_CYC  = 16;
  localparam int CS_LOW_CYC   = 2;
  localparam int CS_HIGH_CYC  = 2;
  localparam int WAIT_TIMEOUT = 1024;
  localparam int CFG_STEPS    = 11;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        host_req, host_we;
  logic [17:0] host_addr;
  logic        rdy0, rdy1, rdy_ready;
  logic        ack0, err0, done0, cs0, rw0, conf0;
  logic        ack1, err1, done1, cs1, rw1, conf1;
  logic [17:0] addr0, addr1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        we;
    logic [17:0] addr;
    int          busy;
    logic        exp_ack;
    int          exp_lat;
  } vec_t;

  vec_t        vecs[5];
  logic [7:0]  cfg_exp0[CFG_STEPS];
  logic [7:0]  cfg_exp1[CFG_STEPS];
  logic [7:0]  cfg0_q[$];
  logic [7:0]  cfg1_q[$];
  logic [18:0] acc_q[$];

  always #5 clk_i = ~clk_i;

  dram_cfg_sequencer dut0 (
    .clk_i(clk_i), .rst_i(rst_i), .host_req_i(host_req), .host_we_i(host_we),
    .host_addr_i(host_addr), .host_ack_o(ack0), .host_err_o(err0),
    .cfg_done_o(done0), .cs_n_o(cs0), .rw_n_o(rw0), .conf_n_o(conf0),
    .addr_o(addr0), .rdy_i(rdy0)
  );

  dram_cfg_sequencer #(
    .REFRESH_IVL(16'h1234), .COL_BITS(4'h9), .RDY_POL(1'b1), .PAGE_MODE(1'b0),
    .DATA_SETUP(1'b1), .DELAY_RDY(1'b1), .DELAYS(56'h77_66_55_44_33_22_11),
    .PAUSE_ON_REF(1'b1)
  ) dut1 (
    .clk_i(clk_i), .rst_i(rst_i), .host_req_i(host_req), .host_we_i(host_we),
    .host_addr_i(host_addr), .host_ack_o(ack1), .host_err_o(err1),
    .cfg_done_o(done1), .cs_n_o(cs1), .rw_n_o(rw1), .conf_n_o(conf1),
    .addr_o(addr1), .rdy_i(rdy1)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Controller RDY model: drops as soon as CSn is low, stays low for
  // busy_len half-cycle-aligned steps, then returns high; stuck forces low.
  int busy_len = 3;
  int bcnt = 0;
  bit served = 1'b1;
  bit stuck = 1'b0;
  always @(negedge clk_i) begin
    if (cs0 === 1'b1) begin
      served = 1'b0;
      bcnt = 0;
    end else if (!served) begin
      bcnt++;
      if (bcnt >= busy_len) served = 1'b1;
    end
  end
  assign rdy_ready = !stuck && !((cs0 === 1'b0) && !served);
  assign rdy0 = rdy_ready;
  assign rdy1 = ~rdy_ready;

  // Scoreboard monitor: pops the expected config byte or access on every
  // CSn falling edge and checks CSn widths during configuration.
  logic prev_cs = 1'b1;
  int lo_len = 0;
  int hi_len = 0;
  always @(negedge clk_i) begin
    logic [7:0]  e0, e1;
    logic [18:0] ea;
    int          idx;
    if (cs0 === 1'b0) begin
      if (prev_cs === 1'b1) begin
        if (conf0 === 1'b0) begin
          idx = CFG_STEPS - cfg0_q.size();
          if (cfg0_q.size() == 0 || cfg1_q.size() == 0) begin
            check("cfg_unexpected_write", 64'(cfg0_q.size()), 64'(1));
          end else begin
            e0 = cfg0_q.pop_front();
            e1 = cfg1_q.pop_front();
            check("cfg_byte", 64'({conf1, addr0, addr1}), 64'({1'b0, 10'b0, e0, 10'b0, e1}));
            if (idx > 0) check("cfg_cs_high", 64'(hi_len), 64'(CS_HIGH_CYC));
          end
        end else begin
          if (acc_q.size() == 0) begin
            check("acc_unexpected", 64'(acc_q.size()), 64'(1));
          end else begin
            ea = acc_q.pop_front();
            check("acc_addr_rw", 64'({rw0, addr0, rw1, addr1, conf1}), 64'({ea, ea, 1'b1}));
          end
        end
        lo_len = 0;
      end
      lo_len++;
    end else begin
      if (prev_cs === 1'b0 && conf0 === 1'b0) check("cfg_cs_low", 64'(lo_len), 64'(CS_LOW_CYC));
      if (prev_cs === 1'b0) hi_len = 0;
      hi_len++;
    end
    prev_cs = cs0;
  end

  task automatic wait_cycles_until_cs_low(output int n);
    n = 0;
    while (cs0 !== 1'b0 && n < 200) begin
      @(posedge clk_i); #1;
      n++;
    end
  endtask

  // Reset (checks reset values on the next edge), reload the scoreboard and
  // watch the power-up delay; optionally wait for the whole config.
  task automatic reset_and_config(input bit wait_done);
    int n;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    check("reset_outputs",
          64'({cs0, rw0, conf0, addr0, ack0, err0, done0, cs1, rw1, conf1, addr1, ack1, err1, done1}),
          64'({3'b111, 18'h0, 3'b000, 3'b111, 18'h0, 3'b000}));
    cfg0_q.delete();
    cfg1_q.delete();
    acc_q.delete();
    for (int i = 0; i < CFG_STEPS; i++) begin
      cfg0_q.push_back(cfg_exp0[i]);
      cfg1_q.push_back(cfg_exp1[i]);
    end
    host_req = 1'b0;
    stuck = 1'b0;
    rst_i = 1'b0;
    wait_cycles_until_cs_low(n);
    check("powerup_cycles", 64'(n), 64'(POWERUP_CYC));
    if (wait_done) begin
      n = 0;
      while (done0 !== 1'b1 && n < 200) begin
        @(posedge clk_i); #1;
        n++;
      end
      check("cfg_done_latency", 64'(n), 64'(CFG_STEPS * (CS_LOW_CYC + CS_HIGH_CYC)));
      check("cfg_done_state", 64'({done0, done1, conf0, conf1, cs0}), 64'(5'b11111));
      check("cfg_all_steps", 64'(cfg0_q.size() + cfg1_q.size()), 64'(0));
    end
  endtask

  // Wait for an already-requested access to start, then for ack or err.
  task automatic wait_access(input logic we, input logic exp_ack, input int exp_lat);
    int   n;
    logic held;
    wait_cycles_until_cs_low(n);
    check("acc_start", 64'({cs0, cs1}), 64'(0));
    n = 0;
    held = 1'b1;
    while (!(ack0 === 1'b1 || err0 === 1'b1) && n < WAIT_TIMEOUT + 50) begin
      @(posedge clk_i); #1;
      n++;
      if (!(ack0 === 1'b1 || err0 === 1'b1))
        if (cs0 !== 1'b0 || rw0 !== ~we || cs1 !== 1'b0 || rw1 !== ~we) held = 1'b0;
    end
    check("acc_latency", 64'(n), 64'(exp_lat));
    check("acc_result", 64'({ack0, err0, ack1, err1}), exp_ack ? 64'(4'b1010) : 64'(4'b0101));
    check("acc_cs_rw_held", 64'(held), 64'(1));
    if (exp_ack) check("acc_release", 64'({cs0, rw0, cs1, rw1}), 64'(4'b1111));
    else         check("err_release", 64'({cs0, cs1}), 64'(2'b11));
  endtask

  task automatic run_access(input vec_t v);
    busy_len  = v.busy;
    host_we   = v.we;
    host_addr = v.addr;
    host_req  = 1'b1;
    acc_q.push_back({~v.we, v.addr});
    wait_access(v.we, v.exp_ack, v.exp_lat);
    host_req = 1'b0;
    @(posedge clk_i); #1;
    check("pulse_width", 64'({ack0, err0, ack1, err1}), 64'(0));
  endtask

  initial begin
    int n;
    vec_t v;
    cfg_exp0 = '{8'hC8, 8'h00, 8'h27, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    cfg_exp1 = '{8'h34, 8'h12, 8'hD9, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h80};
    // Busy cycles below 3 leave RDY high by the first sampled wait cycle,
    // so the access never sees busy and must time out.
    vecs[0] = '{we: 1'b0, addr: 18'h1ABCD, busy: 5, exp_ack: 1'b1, exp_lat: 5};
    vecs[1] = '{we: 1'b1, addr: 18'h00000, busy: 3, exp_ack: 1'b1, exp_lat: 3};
    vecs[2] = '{we: 1'b1, addr: 18'h3FFFF, busy: 9, exp_ack: 1'b1, exp_lat: 9};
    vecs[3] = '{we: 1'b0, addr: 18'h25A5A, busy: 4, exp_ack: 1'b1, exp_lat: 4};
    vecs[4] = '{we: 1'b0, addr: 18'h00001, busy: 2, exp_ack: 1'b0, exp_lat: WAIT_TIMEOUT + 1};

    rst_i = 1'b1;
    host_req = 1'b0;
    host_we = 1'b0;
    host_addr = '0;
    repeat (3) @(posedge clk_i);
    #1;
    reset_and_config(1'b1);

    for (int i = 0; i < 5; i++) run_access(vecs[i]);

    // Back-to-back writes with the request held high across the first ack.
    busy_len = 4;
    host_we = 1'b1;
    host_addr = 18'h12345;
    host_req = 1'b1;
    acc_q.push_back({1'b0, 18'h12345});
    wait_access(1'b1, 1'b1, 4);
    host_addr = 18'h2F00D;
    acc_q.push_back({1'b0, 18'h2F00D});
    wait_cycles_until_cs_low(n);
    check("b2b_cs_gap", 64'(n >= CS_HIGH_CYC), 64'(1));
    wait_access(1'b1, 1'b1, 4);
    host_req = 1'b0;

    // RDY stuck low for 2000 cycles: timeout, then back to IDLE.
    stuck = 1'b1;
    v = '{we: 1'b0, addr: 18'h2AAAA, busy: 5, exp_ack: 1'b0, exp_lat: WAIT_TIMEOUT + 1};
    run_access(v);
    repeat (2000 - WAIT_TIMEOUT - 2) @(posedge clk_i);
    #1;
    check("idle_while_stuck", 64'({cs0, cs1, ack0, err0}), 64'(4'b1100));
    stuck = 1'b0;
    v = '{we: 1'b0, addr: 18'h15555, busy: 6, exp_ack: 1'b1, exp_lat: 6};
    run_access(v);

    // Reset while waiting on RDY.
    stuck = 1'b1;
    host_we = 1'b0;
    host_addr = 18'h0F0F0;
    host_req = 1'b1;
    acc_q.push_back({1'b1, 18'h0F0F0});
    wait_cycles_until_cs_low(n);
    repeat (10) @(posedge clk_i);
    #1;
    check("in_acc_wait", 64'({cs0, ack0, err0}), 64'(0));
    reset_and_config(1'b1);

    // Reset in the middle of a config write, then a full replay.
    reset_and_config(1'b0);
    n = 0;
    while (!(cfg0_q.size() == 7 && cs0 === 1'b0) && n < 200) begin
      @(posedge clk_i); #1;
      n++;
    end
    check("in_cfg_lo", 64'({cs0, conf0, cfg0_q.size() == 7}), 64'(3'b001));
    reset_and_config(1'b1);

    v = '{we: 1'b1, addr: 18'h0ABCD, busy: 5, exp_ack: 1'b1, exp_lat: 5};
    run_access(v);
    check("scoreboard_drained", 64'(acc_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
